// File: rtl/alt_vipcts131_common_frame_gate.sv
// Frame-aligned gate for an Avalon-ST video stream: starts and stops only on frame
// boundaries, and freezes the control registers for the frame in flight.
// state    | meaning
// STOPPED  | idle, nothing accepted, waiting for enable
// WAIT_SOP | enabled, discarding beats until a start of packet
// IN_FRAME | forwarding every beat until end of packet
module alt_vipcts131_common_frame_gate #(
  parameter int DATA_WIDTH    = 24,
  parameter int AV_DATA_WIDTH = 16,
  parameter int NO_REGISTERS  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers,
  output logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] shadow_registers,
  input  logic [DATA_WIDTH-1:0]                 din_data,
  input  logic                                  din_valid,
  input  logic                                  din_sop,
  input  logic                                  din_eop,
  output logic                                  din_ready,
  output logic [DATA_WIDTH-1:0]                 dout_data,
  output logic                                  dout_valid,
  output logic                                  dout_sop,
  output logic                                  dout_eop,
  input  logic                                  dout_ready,
  output logic                                  stopped,
  output logic                                  frame_done,
  output logic [15:0]                           frame_count,
  output logic                                  sop_error
);

  typedef enum logic [1:0] {STOPPED, WAIT_SOP, IN_FRAME} state_t;

  state_t state, state_nxt;
  logic   accept, forward, frame_start, frame_end, sop_err_set, sop_err_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    forward     = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sop_err_set = 1'b0;
    sop_err_clr = 1'b0;
    // ready depends only on registered state and downstream ready
    din_ready   = (state != STOPPED) && (!dout_valid || dout_ready);
    accept      = din_valid && din_ready;
    case (state)
      STOPPED: begin
        if (enable) begin
          state_nxt   = WAIT_SOP;
          sop_err_clr = 1'b1;
        end
      end
      WAIT_SOP: begin
        if (accept && din_sop) begin
          forward     = 1'b1;
          frame_start = 1'b1;
          if (din_eop) begin
            frame_end = 1'b1;
            state_nxt = enable ? WAIT_SOP : STOPPED;
          end else begin
            state_nxt = IN_FRAME;
          end
        end else if (!enable) begin
          state_nxt = STOPPED;
        end
      end
      IN_FRAME: begin
        if (accept) begin
          forward     = 1'b1;
          sop_err_set = din_sop;
          if (din_eop) begin
            frame_end = 1'b1;
            state_nxt = enable ? WAIT_SOP : STOPPED;
          end
        end
      end
      default: state_nxt = STOPPED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else if (forward) begin
      dout_valid <= 1'b1;
      dout_data  <= din_data;
      dout_sop   <= din_sop;
      dout_eop   <= din_eop;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_registers <= '0;
      frame_count      <= '0;
      frame_done       <= 1'b0;
      sop_error        <= 1'b0;
    end else begin
      if (frame_start) shadow_registers <= registers;
      if (frame_end)   frame_count      <= frame_count + 16'd1;
      frame_done <= frame_end;
      if (sop_err_clr)      sop_error <= 1'b0;
      else if (sop_err_set) sop_error <= 1'b1;
    end
  end

  assign stopped = (state == STOPPED) && !dout_valid;

endmodule

// File: doc/alt_vipcts131_common_frame_gate.md
ALT_VIPCTS131_COMMON_FRAME_GATE -- requirements
Module: alt_vipcts131_common_frame_gate

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 24, width of video stream data.
REQ-002 SHALL provide parameter AV_DATA_WIDTH, default 16, width of one control register.
REQ-003 SHALL provide parameter NO_REGISTERS, default 4, number of control registers shadowed.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  go bit from the control register slave.
REQ-007 registers  input  AV_DATA_WIDTH*NO_REGISTERS  live register values from the slave.
REQ-008 shadow_registers  output  AV_DATA_WIDTH*NO_REGISTERS  register values frozen for the current frame.
REQ-009 din_data/din_valid/din_sop/din_eop  input  DATA_WIDTH/1/1/1  upstream Avalon-ST video beat.
REQ-010 din_ready  output  1  upstream backpressure.
REQ-011 dout_data/dout_valid/dout_sop/dout_eop  output  DATA_WIDTH/1/1/1  downstream Avalon-ST beat.
REQ-012 dout_ready  input  1  downstream backpressure.
REQ-013 stopped  output  1  block idle and drained; drives the slave's stopped input.
REQ-014 frame_done  output  1  one-cycle pulse per completed frame; drives a slave interrupt input.
REQ-015 frame_count  output  16  completed-frame counter.
REQ-016 sop_error  output  1  sticky flag, SOP received inside a frame.

Function
REQ-017 SHALL implement states STOPPED, WAIT_SOP, IN_FRAME.
REQ-018 Beat accepted = din_valid && din_ready; din_ready = (state != STOPPED) && (!dout_valid || dout_ready); no combinational dependence on din_sop/din_data.
REQ-019 Output is a single register stage: accepted forwarded beat appears on dout one cycle later; dout_valid held with data stable until dout_ready.
REQ-020 STOPPED: nothing accepted; enable=1 -> WAIT_SOP next cycle.
REQ-021 WAIT_SOP: accepted beats without din_sop discarded (dout not loaded); enable=0 -> STOPPED.
REQ-022 WAIT_SOP, accepted beat with din_sop: beat forwarded, shadow_registers <= registers same edge, -> IN_FRAME (or per REQ-024 if din_eop also set).
REQ-023 IN_FRAME: every accepted beat forwarded; enable changes ignored until frame end.
REQ-024 Accepted beat with din_eop in a frame (including single-beat sop+eop): frame_count increments, frame_done pulses one cycle starting next cycle; next state WAIT_SOP if enable=1 else STOPPED.
REQ-025 Accepted din_sop in IN_FRAME (missing EOP): forwarded unchanged, sop_error <= 1, shadow not reloaded, frame_count unchanged.
REQ-026 sop_error clears only on rst or STOPPED->WAIT_SOP transition.
REQ-027 frame_count wraps 0xFFFF -> 0x0000 without flag.
REQ-028 stopped = (state == STOPPED) && !dout_valid, registered or combinational from registered terms only.
REQ-029 shadow_registers change only per REQ-022; registers changes at other times have no effect.

Reset
REQ-030 On rst: state STOPPED, dout_valid=0, dout_sop=0, dout_eop=0, dout_data=0, shadow_registers=0, frame_count=0, frame_done=0, sop_error=0; hence stopped=1, din_ready=0.
REQ-031 rst mid-frame discards the output-stage beat; no frame_done for the aborted frame.
REQ-032 After rst deassertion, first forwarded beat requires enable=1 and a fresh SOP.

Verification
REQ-033 enable=1, registers={1,2,3,4}, 4-beat frame (sop beat1, eop beat4), dout_ready=1 -> 4 beats out with 1-cycle latency, shadow={1,2,3,4}, frame_count=1, one frame_done pulse.
REQ-034 Registers changed to {5,6,7,8} mid-frame, enable dropped after beat 2 -> frame completes, shadow stays {1,2,3,4}, state STOPPED, stopped=1 once dout drained.
REQ-035 enable=1, 3 non-SOP beats then SOP frame -> first 3 beats consumed and not output; frame forwarded intact.
REQ-036 dout_ready toggled 0/1 every cycle during frame -> no beat lost or duplicated, dout_data stable while dout_valid && !dout_ready.
REQ-037 SOP at beat 3 of a 6-beat frame -> sop_error=1, all 6 beats forwarded, frame_count +1; toggling enable 0->1 via STOPPED clears sop_error.
REQ-038 frame_count preloaded to 0xFFFF via 65535 single-beat frames -> next frame gives 0x0000; rst asserted mid-frame -> dout_valid=0, stopped=1 next cycle.
